// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: hazard and forwarding unit for the in-order pipeline.
// Tracks in-flight register writes across DEPTH post-issue stages and, for
// each source operand of the instruction in decode, picks the youngest
// producer to forward from or stalls issue until that producer is ready.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   issue_valid     decode holds a valid instruction
//   issue_regwrite  instruction writes a register
//   issue_wrreg     destination register
//   issue_lat       first stage at which the result can be forwarded (0 acts as 1)
//   src_used        per-operand "operand is read" flags
//   src_reg         packed source indices, operand i at [i*AW +: AW]
//   flush           redirect from the instruction in stage FLUSH_DEPTH
//   stall           hold IF/ID and insert a bubble
//   issue_fire      instruction leaves decode this cycle
//   fwd_sel         per operand: 0 = register file, k = forward from stage k
//   busy            any valid register write in flight
//   stall_count     saturating count of stalled cycles
module pipe_scoreboard #(
    parameter int unsigned NREG        = 32,
    parameter int unsigned AW          = 5,
    parameter int unsigned NSRC        = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LW          = 3,
    parameter int unsigned SW          = 3,
    parameter int unsigned FLUSH_DEPTH = 3,
    parameter bit          ZERO_REG    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic               issue_regwrite,
    input  logic [AW-1:0]      issue_wrreg,
    input  logic [LW-1:0]      issue_lat,
    input  logic [NSRC-1:0]    src_used,
    input  logic [NSRC*AW-1:0] src_reg,
    input  logic               flush,
    output logic               stall,
    output logic               issue_fire,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic               busy,
    output logic [15:0]        stall_count
);

    // Stage 1 is the youngest entry, stage DEPTH is writeback.
    logic          valid_q [1:DEPTH];
    logic [AW-1:0] wrreg_q [1:DEPTH];
    logic [LW-1:0] lat_q   [1:DEPTH];

    logic          valid_d [1:DEPTH];
    logic [AW-1:0] wrreg_d [1:DEPTH];
    logic [LW-1:0] lat_d   [1:DEPTH];

    logic [NSRC-1:0] stall_op;
    logic [15:0]     stall_count_q, stall_count_d;

    // Operand matching. Walking from oldest to youngest lets the youngest
    // matching producer overwrite any older decision.
    always_comb begin
        stall_op = '0;
        fwd_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (src_used[i] && valid_q[k] &&
                    (wrreg_q[k] == src_reg[i*AW +: AW]) &&
                    !(ZERO_REG && (src_reg[i*AW +: AW] == '0))) begin
                    if (int'(lat_q[k]) <= k) begin
                        fwd_sel[i*SW +: SW] = SW'(k);
                        stall_op[i]         = 1'b0;
                    end else begin
                        fwd_sel[i*SW +: SW] = '0;
                        stall_op[i]         = 1'b1;
                    end
                end
            end
        end
    end

    assign stall      = issue_valid & (|stall_op);
    assign issue_fire = issue_valid & ~stall & ~flush;

    always_comb begin
        busy = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            busy = busy | valid_q[k];
        end
    end

    // Shift with flush squash: entries younger than the redirecting stage
    // are killed on the way into the next stage.
    always_comb begin
        for (int k = 2; k <= DEPTH; k++) begin
            valid_d[k] = valid_q[k-1] & ~(flush && ((k - 1) < FLUSH_DEPTH));
            wrreg_d[k] = wrreg_q[k-1];
            lat_d[k]   = lat_q[k-1];
        end
        valid_d[1] = issue_fire & issue_regwrite;
        wrreg_d[1] = issue_wrreg;
        lat_d[1]   = (issue_lat == '0) ? LW'(1) : issue_lat;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !flush && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                wrreg_q[k] <= '0;
                lat_q[k]   <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                valid_q[k] <= valid_d[k];
                wrreg_q[k] <= wrreg_d[k];
                lat_q[k]   <= lat_d[k];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

`ifndef SYNTHESIS
    // A latency beyond DEPTH never becomes forwardable; it only clears on retire.
    always_ff @(posedge clk) begin
        if (!rst && issue_fire && issue_regwrite) begin
            assert (int'(issue_lat) <= int'(DEPTH))
            else $error("pipe_scoreboard: issue_lat %0d exceeds DEPTH %0d", issue_lat, DEPTH);
            assert (int'(issue_wrreg) < int'(NREG))
            else $error("pipe_scoreboard: issue_wrreg %0d out of range", issue_wrreg);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench for pipe_scoreboard: a driver issues stimulus and pushes the
// expected response from an in-flight-write list model; a monitor compares.
module tb_pipe_scoreboard;

    localparam int NREG = 32, AW = 5, NSRC = 3, DEPTH = 4, LW = 3, SW = 3;
    localparam int FLUSH_DEPTH = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue_valid, issue_regwrite, flush;
    logic [AW-1:0]      issue_wrreg;
    logic [LW-1:0]      issue_lat;
    logic [NSRC-1:0]    src_used;
    logic [NSRC*AW-1:0] src_reg;
    logic               stall, issue_fire, busy;
    logic [NSRC*SW-1:0] fwd_sel;
    logic [15:0]        stall_count;

    always #5 clk = ~clk;

    pipe_scoreboard #(
        .NREG(NREG), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LW(LW), .SW(SW),
        .FLUSH_DEPTH(FLUSH_DEPTH), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
        .issue_wrreg(issue_wrreg), .issue_lat(issue_lat), .src_used(src_used),
        .src_reg(src_reg), .flush(flush), .stall(stall), .issue_fire(issue_fire),
        .fwd_sel(fwd_sel), .busy(busy), .stall_count(stall_count)
    );

    typedef struct {
        logic               stall;
        logic               fire;
        logic               busy;
        logic [NSRC*SW-1:0] fwd;
        logic [15:0]        cnt;
        int                 phase;
    } exp_t;

    // A write in flight: age equals the stage it currently occupies.
    typedef struct {
        int r;
        int lat;
        int age;
    } rec_t;

    exp_t exp_q[$];
    rec_t recs[$];
    int   model_cnt;
    int   phase;
    int   vectors;
    int   miscompares;
    bit   done;

    // Drive one cycle of inputs, push the model's expectation, then advance
    // the model across the clock edge.
    task automatic apply(input bit v, input bit rw, input int wr, input int lat,
                         input bit [2:0] used, input int s0, input int s1, input int s2,
                         input bit fl, input bit rs);
        exp_t e;
        int   srcs[3];
        int   lat_eff;
        rec_t nrec;
        rec_t keep[$];
        srcs[0] = s0; srcs[1] = s1; srcs[2] = s2;
        issue_valid    = v;
        issue_regwrite = rw;
        issue_wrreg    = AW'(wr);
        issue_lat      = LW'(lat);
        src_used       = used;
        src_reg        = {AW'(s2), AW'(s1), AW'(s0)};
        flush          = fl;
        rst            = rs;

        e.fwd   = '0;
        e.stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            int best = -1;
            for (int j = 0; j < recs.size(); j++) begin
                if (used[i] && recs[j].r == srcs[i] && srcs[i] != 0 &&
                    (best < 0 || recs[j].age < recs[best].age)) best = j;
            end
            if (best >= 0) begin
                if (recs[best].age >= recs[best].lat) e.fwd[i*SW +: SW] = SW'(recs[best].age);
                else e.stall = v;
            end
        end
        e.fire  = v && !e.stall && !fl;
        e.busy  = (recs.size() > 0);
        e.cnt   = 16'(model_cnt);
        e.phase = phase;
        exp_q.push_back(e);

        @(posedge clk);
        if (rs) begin
            recs.delete();
            model_cnt = 0;
        end else begin
            if (e.stall && !fl && model_cnt < 65535) model_cnt++;
            foreach (recs[j]) begin
                if (!(fl && recs[j].age < FLUSH_DEPTH) && recs[j].age < DEPTH) begin
                    nrec = recs[j];
                    nrec.age++;
                    keep.push_back(nrec);
                end
            end
            recs = keep;
            if (e.fire && rw) begin
                lat_eff = (lat == 0) ? 1 : lat;
                nrec.r = wr; nrec.lat = lat_eff; nrec.age = 1;
                recs.push_back(nrec);
            end
        end
        #1;
    endtask

    task automatic iss(input int wr, input int lat);
        apply(1, 1, wr, lat, 3'b000, 0, 0, 0, 0, 0);
    endtask

    task automatic nop();
        apply(0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input bit [2:0] used, input int s0, input int s1, input int s2);
        apply(1, 0, 0, 1, used, s0, s1, s2, 0, 0);
    endtask

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want,
                                input int ph);
        if (got !== want) begin
            miscompares++;
            $display("FAIL phase %0d %s: got %0h want %0h", ph, nm, got, want);
        end
    endfunction

    // Monitor: combinational outputs are present every cycle, sample mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            chk("stall", 32'(stall), 32'(e.stall), e.phase);
            chk("issue_fire", 32'(issue_fire), 32'(e.fire), e.phase);
            chk("busy", 32'(busy), 32'(e.busy), e.phase);
            chk("fwd_sel", 32'(fwd_sel), 32'(e.fwd), e.phase);
            chk("stall_count", 32'(stall_count), 32'(e.cnt), e.phase);
        end
    end

    initial begin
        vectors = 0; miscompares = 0; model_cnt = 0; phase = 0; done = 0;
        rst = 1; issue_valid = 0; issue_regwrite = 0; issue_wrreg = '0; issue_lat = 3'd1;
        src_used = '0; src_reg = '0; flush = 0;
        // Initial reset without checks: DUT state is unknown until the first edge.
        @(posedge clk); #1;

        phase = 1;  // reset, then a read with nothing in flight
        apply(0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 1);
        rd(3'b001, 3, 0, 0);
        nop();

        phase = 2;  // ALU chain at distances 1, 2 and 5
        iss(5, 1); rd(3'b001, 5, 0, 0);
        repeat (5) nop();
        iss(5, 1); nop(); rd(3'b001, 5, 0, 0);
        repeat (5) nop();
        iss(5, 1); repeat (4) nop(); rd(3'b001, 5, 0, 0);

        phase = 3;  // load-use: stall once, then forward from stage 2
        iss(7, 2); rd(3'b010, 0, 7, 0); rd(3'b010, 0, 7, 0);
        repeat (5) nop();
        phase = 4;  // load-load through src2
        iss(7, 2);
        apply(1, 1, 8, 2, 3'b100, 0, 0, 7, 0, 0);
        apply(1, 1, 8, 2, 3'b100, 0, 0, 7, 0, 0);
        repeat (5) nop();

        phase = 5;  // youngest producer wins
        iss(4, 1); iss(4, 1); rd(3'b101, 4, 0, 4);
        repeat (5) nop();

        phase = 6;  // zero register and unused operands
        iss(0, 1); rd(3'b001, 0, 0, 0);
        iss(6, 2); rd(3'b101, 1, 6, 2);
        repeat (5) nop();

        phase = 7;  // flush with two young producers and an incoming issue
        iss(9, 1); iss(10, 1);
        apply(1, 1, 11, 1, 3'b000, 0, 0, 0, 1, 0);
        rd(3'b111, 9, 10, 11);
        repeat (5) nop();
        phase = 8;  // flush where the older producer already sits in stage FLUSH_DEPTH
        iss(9, 1); nop(); iss(10, 1);
        apply(1, 1, 11, 1, 3'b000, 0, 0, 0, 1, 0);
        rd(3'b111, 9, 10, 11);
        repeat (5) nop();
        phase = 9;  // concurrent stall and flush leave stall_count alone
        iss(7, 2);
        apply(1, 0, 0, 1, 3'b001, 7, 0, 0, 1, 0);
        nop();

        phase = 10; // reset mid-operation
        iss(1, 1); iss(2, 1);
        apply(1, 1, 3, 1, 3'b001, 1, 0, 0, 0, 1);
        nop();

        phase = 11; // randomized traffic on a small register window
        for (int n = 0; n < 2000; n++) begin
            apply($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH)),
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
